// File: rtl/sms_timing_ring_if.sv
// Bundle of the control inputs and stage outputs of the SMS trigger chain.
// Controls are plain levels sampled on the rising clock edge. There is no valid/ready
// pairing: start, stop_req, adv and load take effect only in the controller states that honour them.
interface sms_timing_ring_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop_req;
  logic             adv;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             run;
  logic             tc;
  logic             cycle_done;
  logic             load_err;
  logic [1:0]       state;

  modport master (
    output start, stop_req, adv, load, load_val,
    input  q, run, tc, cycle_done, load_err, state
  );

  modport slave (
    input  start, stop_req, adv, load, load_val,
    output q, run, tc, cycle_done, load_err, state
  );
endinterface

// File: rtl/sms_timing_ring.sv
// WIDTH-stage trigger chain that runs as a binary counter, a one-hot ring or a Johnson ring,
// with a run/stop controller that can finish the current cycle before halting.
module sms_timing_ring #(
  parameter int WIDTH       = 4,
  parameter int MODE        = 0,
  parameter int STOP_AT_END = 1
) (
  input logic              clk,
  input logic              rst,
  sms_timing_ring_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] HOME     = (MODE == 1) ? ONE : '0;
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, q_step, q_nxt;
  logic             tc, step_en, wrap, load_hit, load_ok;
  logic             cycle_done, load_err;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + int'(v[i]);
    return cnt == 1;
  endfunction

  // A legal Johnson code has at most one boundary between its run of ones and its run of zeros.
  function automatic logic is_johnson(input logic [WIDTH-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < WIDTH - 1; i++) cnt = cnt + int'(v[i] != v[i+1]);
    return cnt <= 1;
  endfunction

  always_comb begin
    tc      = 1'b0;
    q_step  = q;
    load_ok = 1'b1;
    if (MODE == 1) begin
      tc      = q[WIDTH-1];
      q_step  = {q[WIDTH-2:0], q[WIDTH-1]};
      load_ok = is_onehot(bus.load_val);
    end else if (MODE == 2) begin
      tc      = (q == MSB_ONLY);
      q_step  = {q[WIDTH-2:0], ~q[WIDTH-1]};
      load_ok = is_johnson(bus.load_val);
    end else begin
      tc      = &q;
      q_step  = q + ONE;
    end
  end

  assign step_en  = bus.adv && (state != IDLE);
  assign wrap     = step_en && tc;
  assign load_hit = bus.load && (state == IDLE);

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop_req) state_nxt = RUN;
      end
      RUN: begin
        if (bus.stop_req) state_nxt = (STOP_AT_END != 0) ? STOPPING : IDLE;
      end
      STOPPING: begin
        if (wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // An illegal ring/Johnson load parks the chain at home rather than loading a bad code.
    if (load_hit)     q_nxt = load_ok ? bus.load_val : HOME;
    else if (step_en) q_nxt = q_step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      q          <= HOME;
      cycle_done <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      q          <= q_nxt;
      cycle_done <= wrap;
      if (load_hit) load_err <= !load_ok;
    end
  end

  assign bus.q          = q;
  assign bus.run        = (state != IDLE);
  assign bus.tc         = tc;
  assign bus.cycle_done = cycle_done;
  assign bus.load_err   = load_err;
  assign bus.state      = state;
endmodule

// File: tb/tb_sms_timing_ring.sv
// Directed bench for sms_timing_ring: binary, ring and Johnson chains, stop modes, loads, async reset.
module tb_sms_timing_ring;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   pulses;
  int   exp_q;
  logic [3:0] rseq [4];
  logic [2:0] jseq [6];

  sms_timing_ring_if #(.WIDTH(4)) bi1 ();
  sms_timing_ring_if #(.WIDTH(4)) bi0 ();
  sms_timing_ring_if #(.WIDTH(4)) ri ();
  sms_timing_ring_if #(.WIDTH(3)) ji ();

  sms_timing_ring #(.WIDTH(4), .MODE(0), .STOP_AT_END(1)) u_bin1 (.clk(clk), .rst(rst), .bus(bi1));
  sms_timing_ring #(.WIDTH(4), .MODE(0), .STOP_AT_END(0)) u_bin0 (.clk(clk), .rst(rst), .bus(bi0));
  sms_timing_ring #(.WIDTH(4), .MODE(1), .STOP_AT_END(1)) u_ring (.clk(clk), .rst(rst), .bus(ri));
  sms_timing_ring #(.WIDTH(3), .MODE(2), .STOP_AT_END(1)) u_john (.clk(clk), .rst(rst), .bus(ji));

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bi1.start = 0; bi1.stop_req = 0; bi1.adv = 0; bi1.load = 0; bi1.load_val = '0;
    bi0.start = 0; bi0.stop_req = 0; bi0.adv = 0; bi0.load = 0; bi0.load_val = '0;
    ri.start  = 0; ri.stop_req  = 0; ri.adv  = 0; ri.load  = 0; ri.load_val  = '0;
    ji.start  = 0; ji.stop_req  = 0; ji.adv  = 0; ji.load  = 0; ji.load_val  = '0;
    rseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    jseq = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};

    // reset state
    #2;
    chk("rst_bin_q", bi1.q, 0);
    chk("rst_bin_run", bi1.run, 0);
    chk("rst_bin_tc", bi1.tc, 0);
    chk("rst_bin_cd", bi1.cycle_done, 0);
    chk("rst_ring_q", ri.q, 1);
    chk("rst_ring_tc", ri.tc, 0);
    chk("rst_ring_err", ri.load_err, 0);
    chk("rst_john_q", ji.q, 0);
    chk("rst_john_tc", ji.tc, 0);
    #10;
    rst = 1'b0;

    // binary counting through one full wrap
    bi1.start = 1;
    tick();
    chk("bin_start_run", bi1.run, 1);
    chk("bin_start_q", bi1.q, 0);
    bi1.start = 0;
    bi1.adv = 1;
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_q = i % 16;
      chk("bin_q", bi1.q, exp_q);
      chk("bin_tc", bi1.tc, (exp_q == 15));
      chk("bin_cd", bi1.cycle_done, (i == 16));
      chk("bin_run", bi1.run, 1);
      if (bi1.cycle_done) pulses++;
    end
    bi1.adv = 0;
    tick();
    chk("bin_hold_q", bi1.q, 0);
    chk("bin_hold_cd", bi1.cycle_done, 0);
    chk("bin_pulses", pulses, 1);

    // stop at end of cycle
    bi1.adv = 1;
    repeat (5) tick();
    chk("stop1_q5", bi1.q, 5);
    bi1.stop_req = 1;
    tick();
    bi1.stop_req = 0;
    chk("stop1_q6", bi1.q, 6);
    chk("stop1_state", bi1.state, 2);
    bi1.start = 1;
    exp_q = 6;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_q = (exp_q + 1) % 16;
      chk("stop1_q", bi1.q, exp_q);
      chk("stop1_run", bi1.run, (exp_q != 0));
      chk("stop1_cd", bi1.cycle_done, (exp_q == 0));
      if (bi1.cycle_done) pulses++;
    end
    bi1.start = 0;
    tick();
    chk("stop1_idle_q", bi1.q, 0);
    chk("stop1_idle_run", bi1.run, 0);
    chk("stop1_idle_cd", bi1.cycle_done, 0);
    chk("stop1_pulses", pulses, 1);
    bi1.adv = 0;

    // immediate stop
    bi0.start = 1;
    tick();
    bi0.start = 0;
    bi0.adv = 1;
    repeat (5) tick();
    chk("stop0_q5", bi0.q, 5);
    bi0.adv = 0;
    bi0.stop_req = 1;
    tick();
    chk("stop0_run", bi0.run, 0);
    chk("stop0_q", bi0.q, 5);
    chk("stop0_cd", bi0.cycle_done, 0);
    bi0.stop_req = 0;
    bi0.adv = 1;
    tick();
    chk("stop0_idle_q", bi0.q, 5);
    chk("stop0_idle_run", bi0.run, 0);
    bi0.start = 1;
    tick();
    chk("stop0_restart_q", bi0.q, 5);
    chk("stop0_restart_run", bi0.run, 1);
    bi0.start = 0;
    bi0.stop_req = 1;
    tick();
    chk("stop0_adv_q", bi0.q, 6);
    chk("stop0_adv_run", bi0.run, 0);
    bi0.adv = 0;
    bi0.start = 1;
    tick();
    chk("start_with_stop_run", bi0.run, 0);
    bi0.start = 0;
    bi0.stop_req = 0;

    // ring loads and counting
    ri.load = 1;
    ri.load_val = 4'b0110;
    tick();
    chk("ring_bad_q", ri.q, 1);
    chk("ring_bad_err", ri.load_err, 1);
    ri.load_val = 4'b0100;
    tick();
    chk("ring_good_q", ri.q, 4);
    chk("ring_good_err", ri.load_err, 0);
    ri.load_val = 4'b0001;
    tick();
    ri.load = 0;
    ri.start = 1;
    tick();
    chk("ring_run", ri.run, 1);
    chk("ring_q0", ri.q, 1);
    ri.start = 0;
    ri.adv = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ring_q", ri.q, rseq[i]);
      chk("ring_tc", ri.tc, (rseq[i] == 4'b1000));
      chk("ring_cd", ri.cycle_done, (i == 3));
    end
    ri.adv = 0;
    ri.load = 1;
    ri.load_val = 4'b1000;
    tick();
    chk("ring_runload_q", ri.q, 1);
    chk("ring_runload_err", ri.load_err, 0);
    ri.load = 0;

    // Johnson: illegal load, load with start, then gated counting
    ji.load = 1;
    ji.load_val = 3'b010;
    tick();
    chk("john_bad_q", ji.q, 0);
    chk("john_bad_err", ji.load_err, 1);
    ji.load_val = 3'b011;
    ji.start = 1;
    tick();
    chk("john_ldstart_q", ji.q, 3);
    chk("john_ldstart_run", ji.run, 1);
    chk("john_ldstart_err", ji.load_err, 0);
    ji.load = 0;
    ji.start = 0;
    ji.adv = 1;
    tick();
    chk("john_first_step", ji.q, 7);
    tick();
    tick();
    chk("john_q100", ji.q, 4);
    chk("john_tc100", ji.tc, 1);
    tick();
    chk("john_wrap_q", ji.q, 0);
    chk("john_wrap_cd", ji.cycle_done, 1);
    chk("john_wrap_run", ji.run, 1);
    for (int i = 0; i < 12; i++) begin
      ji.adv = (i % 2 == 0);
      tick();
      chk("john_gate_q", ji.q, jseq[i/2]);
      chk("john_gate_tc", ji.tc, (jseq[i/2] == 3'b100));
      chk("john_gate_cd", ji.cycle_done, (i == 10));
    end
    ji.adv = 0;

    // asynchronous reset mid-cycle
    bi1.start = 1;
    tick();
    bi1.start = 0;
    bi1.adv = 1;
    repeat (9) tick();
    chk("arst_pre_q", bi1.q, 9);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_q", bi1.q, 0);
    chk("arst_run", bi1.run, 0);
    chk("arst_ring_q", ri.q, 1);
    chk("arst_john_run", ji.run, 0);
    #1;
    rst = 1'b0;
    bi1.adv = 0;
    bi1.start = 1;
    tick();
    chk("arst_restart_run", bi1.run, 1);
    chk("arst_restart_q", bi1.q, 0);
    bi1.start = 0;
    bi1.adv = 1;
    tick();
    chk("arst_restart_step", bi1.q, 1);
    bi1.adv = 0;

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sms_timing_ring.md
# sms_timing_ring

Parametrised trigger chain for the SMS card library. It generalises the single binary trigger (TAJ) into a WIDTH-stage timing source. The chain runs as a binary counter, a one-hot timing ring or a Johnson ring, and has a run/stop control that can halt at a cycle boundary. It sits behind the oscillator model and drives timing gates for downstream card logic.

## Interface
Parameters:
- WIDTH, 4: number of trigger stages; legal range 2..16.
- MODE, 0: 0 = binary up counter, 1 = one-hot ring, 2 = Johnson (twisted) ring.
- STOP_AT_END, 1: 1 = stop request completes at the next wrap; 0 = stop request halts immediately.

Ports:
- clk  in  1  oscillator clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled when idle.
- stop_req  in  1  stop request; sampled while running.
- adv  in  1  advance gate; chain steps only when adv=1 and running.
- load  in  1  parallel load strobe; honoured only when idle.
- load_val  in  WIDTH  parallel load value.
- q  out  WIDTH  trigger stage outputs.
- run  out  1  1 while in RUN or STOPPING.
- tc  out  1  combinational terminal-state decode of q.
- cycle_done  out  1  one-cycle pulse after each wrap to home.
- load_err  out  1  sticky flag for an illegal load value.

## Operation
- Home state: binary 0; ring 1 (bit 0 set); Johnson 0.
- Step rules:
  - Binary: q+1 modulo 2^WIDTH.
  - Ring: rotate left; MSB feeds bit 0.
  - Johnson: shift left; bit 0 takes ~MSB; the sequence has 2*WIDTH states.
- Terminal state (tc):
  - Binary: q is all ones.
  - Ring: q[WIDTH-1] set.
  - Johnson: only the MSB is set.
- A step from the terminal state is a wrap to home.
- Controller states: IDLE, RUN, STOPPING.
  - IDLE: q holds. start=1 and stop_req=0 goes to RUN. start=1 with stop_req=1 stays IDLE.
  - RUN: steps on adv. stop_req=1 goes to STOPPING when STOP_AT_END=1, or to IDLE with q held when STOP_AT_END=0. start is ignored.
  - STOPPING: steps on adv. A wrap goes to IDLE, with q at home on the same edge. Further stop_req and start are ignored.
- Wrap in RUN: the controller stays in RUN and the chain continues.
- stop_req in the same cycle as a wrap, in RUN with STOP_AT_END=1: go to STOPPING. The chain then runs one more full cycle.
- Load, IDLE only:
  - Binary: any value is legal; q = load_val.
  - Ring: the value must be exactly one-hot.
  - Johnson: the value must be a legal Johnson code (0*1* or 1*0*, contiguous).
  - Illegal ring or Johnson value: q = home and load_err=1.
  - A legal load clears load_err.
  - load and start together in IDLE: the load applies and the controller goes to RUN on the same edge. The first step uses the loaded value.
  - load in RUN or STOPPING is ignored.

## Timing
- Reset (asynchronous, immediate): q=home, run=0, cycle_done=0, load_err=0, controller IDLE. tc=0 in all modes at home.
- start sampled at edge k gives run=1 after edge k. The first possible step is at edge k+1.
- Step latency is one edge: adv=1 at edge k means q updates after edge k.
- cycle_done is registered. It is high for exactly the cycle after the wrapping edge, which is the cycle in which q shows home.
- In STOPPING, run falls after the wrapping edge, and cycle_done pulses in that same cycle.
- With STOP_AT_END=0, run falls after the edge that samples stop_req. cycle_done pulses only if that edge also wrapped.
- With adv=0, nothing advances and no cycle_done occurs, in any state.
- Reset mid-run overrides everything, including a pending wrap or load.

## Test plan
- Binary counting: MODE=0, WIDTH=4, start then 17 edges with adv=1 -> q steps 0..15 then 0; tc high only at q=15; one cycle_done pulse, in the cycle q=0.
- Ring counting: MODE=1, WIDTH=4, run 5 steps -> q = 0001, 0010, 0100, 1000, 0001; tc high at 1000.
- Johnson counting and gating: MODE=2, WIDTH=3 -> q = 000, 001, 011, 111, 110, 100, 000; tc high at 100. With adv toggling 1/0, each state holds exactly 2 cycles.
- Stop behaviour, MODE=0, WIDTH=4:
  - STOP_AT_END=1, stop_req at q=5 -> q continues to 15, then 0; run falls with q=0; cycle_done pulses once.
  - STOP_AT_END=0, same stimulus -> q holds 5 (6 if adv was high on the sampling edge); run=0; no cycle_done.
- Load checks, MODE=1, WIDTH=4:
  - load_val=0110 in IDLE -> q=0001, load_err=1.
  - Then load_val=0100 -> q=0100, load_err=0.
  - load during RUN -> q unaffected.
- Asynchronous reset: assert rst mid-cycle while running at q=9 (MODE=0) -> q=0 and run=0 immediately, without waiting for an edge. The bench then shows start restarting from 0.
